capture_sequencer: RTL and testbench
====================================

# capture_sequencer

Control-and-buffer block for the 8-bit trigger-capture datapath. It arms on request and waits for `trig`. On trigger it records a programmable-length burst of `din` samples into an internal buffer. It then drains the burst to a downstream consumer over a valid/ready handshake. It is the sequencer that turns the single-cycle trigger-capture path into a repeatable armed-capture-readout transaction.

## Interface
- `DW`, default 8: sample width.
- `DEPTH`, default 16: buffer depth in samples. Must be a power of two, at least 2.
- `CW`, default `$clog2(DEPTH)+1`: width of the length and count fields.

Ports:
- `clk`, input, 1: sole clock; all state updates on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `arm`, input, 1: single-cycle request to start a capture transaction.
- `abort`, input, 1: cancels any transaction.
- `trig`, input, 1: capture trigger, sampled synchronously.
- `din`, input, DW: sample stream.
- `post_len`, input, CW: burst length; sampled when `arm` is accepted.
- `busy`, output, 1: high in any state other than IDLE.
- `armed`, output, 1: high in ARMED.
- `rd_valid`, output, 1: a buffered sample is presented.
- `rd_ready`, input, 1: consumer accepts the sample.
- `rd_data`, output, DW: presented sample.
- `done`, output, 1: one-cycle pulse when the last sample is accepted.

## Operation
- FSM states: IDLE, ARMED, CAPTURE, DRAIN.
- **IDLE:**
  - `arm` moves the FSM to ARMED.
  - The effective length `len` is latched as `post_len` clamped: 0 becomes 1, values above DEPTH become DEPTH.
  - `trig` is ignored in IDLE.
- **ARMED:**
  - `trig` high at an edge writes `din` to `buf[0]`, sets `wr_cnt` to 1, and moves to CAPTURE.
  - If `len`==1 it moves directly to DRAIN instead.
- **CAPTURE:**
  - Every edge writes `din` to `buf[wr_cnt]` and increments `wr_cnt`, regardless of `trig`.
  - At the edge that writes the sample with index `len`-1, the FSM moves to DRAIN.
- **DRAIN:**
  - `rd_valid` is high, and `rd_data` is `buf[rd_cnt]`.
  - Each edge with `rd_valid`&&`rd_ready` increments `rd_cnt`.
  - The handshake on index `len`-1 pulses `done`, clears the counters and returns to IDLE.
- `rd_data` is held stable while `rd_valid`&&!`rd_ready`.
- Counters are CW bits wide and never wrap, because `len` is at most DEPTH.
- `arm` outside IDLE is ignored. A new `len` is not latched mid-transaction.
- `abort` in any state returns to IDLE at the next edge, clears the counters and `rd_valid`, and produces no `done`. Buffer contents become don't-care.
- `abort` and `arm` in the same cycle: `abort` wins and the FSM stays in IDLE.
- `abort` coinciding with the final DRAIN handshake: `abort` wins and there is no `done`.
- Reset mid-operation behaves identically to `abort`, but is immediate (asynchronous).

## Timing
- Reset values:
  - state IDLE; `busy`=0, `armed`=0, `rd_valid`=0, `done`=0, `rd_data`=0.
  - `wr_cnt`=0, `rd_cnt`=0, `len`=1.
- `arm` at edge a: `armed` is high from a+1.
- Trigger at edge k: samples are captured at edges k through k+`len`-1.
- `rd_valid` rises after edge k+`len`-1. The first sample is available one cycle after the last capture edge.
- With `rd_ready` tied high, drain takes `len` cycles. `done` is high for the cycle following the final handshake edge.
- `busy` falls in the same cycle that `done` is high.
- Back-to-back operation: `arm` may be asserted in the `done` cycle and is accepted.

## Configuration
- `CAPTURE_TS_EN` defined:
  - Adds a free-running 16-bit cycle counter, reset to 0, which wraps.
  - Adds output `trig_ts`, 16 bits: the counter value at the trigger edge, held until the next trigger. Its reset value is 0.
- `CAPTURE_TS_EN` undefined: the port `trig_ts` and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `capture_pkg`:
  - state enum `cap_state_t` (IDLE, ARMED, CAPTURE, DRAIN);
  - default DW and DEPTH constants;
  - timestamp width constant (16).
- One natural sub-module, `capture_buf`: a DEPTH×DW register array with a synchronous write port and an asynchronous read port indexed by `rd_cnt`.
- FSM, counters and clamping logic reside in `capture_sequencer`.

## Test plan
- Burst of 4 with `rd_ready` tied high:
  - Stimulus: reset; `arm` with `post_len`=4; `din` counts 0x10 upward from the trigger edge; `trig` at edge 5.
  - Expected: `rd_data` 0x10, 0x11, 0x12, 0x13 on consecutive cycles, then a single `done` pulse and `busy` low.
- Length clamping:
  - `post_len`=0 gives exactly one sample.
  - `post_len`=31 with DEPTH 16 gives 16 samples, with `wr_cnt` never exceeding 16.
- Backpressure: toggle `rd_ready` 1,0,0,1 during drain. `rd_data` must hold across the stall cycles, and each sample must be delivered exactly once, in order.
- Abort and reset:
  - `abort` in ARMED, in mid-CAPTURE and in mid-DRAIN returns to IDLE next cycle with no `done`.
  - `arm`+`abort` together leaves the FSM in IDLE.
  - Asynchronous `rst_n` low mid-DRAIN clears `rd_valid` immediately.
- Ignored inputs:
  - `trig` in IDLE causes no capture.
  - `arm` during CAPTURE does not change `len`.
  - `arm` in the `done` cycle re-arms the block.
- `CAPTURE_TS_EN`: with the trigger at counter value 0x0123, `trig_ts`=0x0123 until the next trigger. Also check wrap from 0xFFFF to 0x0000.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared types and constants for the trigger-capture sequencer.
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } cap_state_t;

    localparam int CAP_DW_DEF    = 8;
    localparam int CAP_DEPTH_DEF = 16;
    localparam int CAP_TS_W      = 16;

endpackage

// File: rtl/capture_buf.sv
// Burst sample buffer: DEPTH x DW registers, synchronous write, asynchronous read.
module capture_buf #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/capture_sequencer.sv
// Armed-capture-readout sequencer: arm, wait for trigger, capture a burst, drain over valid/ready.
// Define CAPTURE_TS_EN to add a free-running cycle counter and the o_trig_ts trigger timestamp.
//
// state   | meaning
// IDLE    | no transaction; arm latches the clamped burst length
// ARMED   | waiting for trigger; trigger captures sample 0
// CAPTURE | one sample written per cycle until index len-1
// DRAIN   | buffer presented on rd_valid/rd_data until index len-1 is accepted
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int DW    = CAP_DW_DEF,
    parameter int DEPTH = CAP_DEPTH_DEF,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_arm,
    input  logic          i_abort,
    input  logic          i_trig,
    input  logic [DW-1:0] i_din,
    input  logic [CW-1:0] i_post_len,
    output logic          o_busy,
    output logic          o_armed,
    output logic          o_rd_valid,
    input  logic          i_rd_ready,
    output logic [DW-1:0] o_rd_data,
`ifdef CAPTURE_TS_EN
    output logic [CAP_TS_W-1:0] o_trig_ts,
`endif
    output logic          o_done
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] LEN_MAX = CW'(DEPTH);

    cap_state_t    r_state;
    cap_state_t    w_state_nxt;
    logic [CW-1:0] r_len;
    logic [CW-1:0] r_wr_cnt;
    logic [CW-1:0] r_rd_cnt;
    logic          r_done;
    logic [CW-1:0] w_len_clamped;
    logic          w_trig_go;
    logic          w_wr_en;
    logic          w_last_wr;
    logic          w_hs;
    logic          w_last_rd;
    logic [DW-1:0] w_buf_rdata;

    always_comb begin
        w_len_clamped = i_post_len;
        if (i_post_len == '0) begin
            w_len_clamped = ONE;
        end else if (i_post_len > LEN_MAX) begin
            w_len_clamped = LEN_MAX;
        end
    end

    // wr_cnt is still 0 in ARMED, so it doubles as the write address for sample 0
    assign w_trig_go = (r_state == ARMED) && i_trig;
    assign w_wr_en   = !i_abort && (w_trig_go || (r_state == CAPTURE));
    assign w_last_wr = (r_state == CAPTURE) && (r_wr_cnt == r_len - ONE);
    assign w_hs      = (r_state == DRAIN) && i_rd_ready;
    assign w_last_rd = w_hs && (r_rd_cnt == r_len - ONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_arm) w_state_nxt = ARMED;
            ARMED:   if (i_trig) w_state_nxt = (r_len == ONE) ? DRAIN : CAPTURE;
            CAPTURE: if (w_last_wr) w_state_nxt = DRAIN;
            DRAIN:   if (w_last_rd) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (i_abort) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len    <= ONE;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_done   <= 1'b0;
        end else if (i_abort) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last_rd;
            if ((r_state == IDLE) && i_arm) begin
                r_len <= w_len_clamped;
            end
            if (w_last_rd) begin
                r_wr_cnt <= '0;
                r_rd_cnt <= '0;
            end else begin
                if (w_wr_en) r_wr_cnt <= r_wr_cnt + ONE;
                if (w_hs)    r_rd_cnt <= r_rd_cnt + ONE;
            end
        end
    end

    capture_buf #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .i_clk   (i_clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_cnt[AW-1:0]),
        .i_wdata (i_din),
        .i_raddr (r_rd_cnt[AW-1:0]),
        .o_rdata (w_buf_rdata)
    );

    assign o_busy     = (r_state != IDLE);
    assign o_armed    = (r_state == ARMED);
    assign o_rd_valid = (r_state == DRAIN);
    assign o_rd_data  = o_rd_valid ? w_buf_rdata : '0;
    assign o_done     = r_done;

`ifdef CAPTURE_TS_EN
    logic [CAP_TS_W-1:0] r_ts_cnt;
    logic [CAP_TS_W-1:0] r_trig_ts;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ts_cnt  <= '0;
            r_trig_ts <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + CAP_TS_W'(1);
            if (w_trig_go && !i_abort) begin
                r_trig_ts <= r_ts_cnt;
            end
        end
    end

    assign o_trig_ts = r_trig_ts;
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer; define CAPTURE_TS_EN to also exercise the timestamp.
module tb_capture_sequencer;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          arm      = 1'b0;
    logic          abort    = 1'b0;
    logic          trig     = 1'b0;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] din      = '0;
    logic [CW-1:0] post_len = '0;
    logic          busy;
    logic          armed;
    logic          rd_valid;
    logic          done;
    logic [DW-1:0] rd_data;
`ifdef CAPTURE_TS_EN
    logic [15:0]   trig_ts;
    logic [15:0]   tb_ts;
`endif

    int            n_chk    = 0;
    int            n_pass   = 0;
    int            done_cnt = 0;
    int            exp_done = 0;
    int            d0;
    logic [DW-1:0] exp_q[$];
    logic [3:0]    bp_pat   = 4'b1001;

    always #5 clk = ~clk;

    capture_sequencer dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_arm      (arm),
        .i_abort    (abort),
        .i_trig     (trig),
        .i_din      (din),
        .i_post_len (post_len),
        .o_busy     (busy),
        .o_armed    (armed),
        .o_rd_valid (rd_valid),
        .i_rd_ready (rd_ready),
        .o_rd_data  (rd_data),
`ifdef CAPTURE_TS_EN
        .o_trig_ts  (trig_ts),
`endif
        .o_done     (done)
    );

`ifdef CAPTURE_TS_EN
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= '0;
        else        tb_ts <= tb_ts + 16'd1;
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // presented data must match the oldest outstanding sample, also across stalls
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy) check("wr_cnt_bound", {31'b0, (dut.r_wr_cnt <= 5'd16)}, 1);
        if (rd_valid) begin
            check("rd_q_nonempty", {31'b0, (exp_q.size() > 0)}, 1);
            if (exp_q.size() > 0) begin
                check("rd_data", {24'b0, rd_data}, {24'b0, exp_q[0]});
                if (rd_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int pl);
        arm      = 1'b1;
        post_len = CW'(pl);
        tick();
        arm      = 1'b0;
        check("armed_after_arm", {31'b0, armed}, 1);
    endtask

    task automatic do_capture(input int eff, input logic [DW-1:0] base, input bit mid_arm);
        for (int i = 0; i < eff; i++) begin
            din  = base + DW'(i);
            trig = (i == 0);
            if (mid_arm && i == 1) begin
                arm      = 1'b1;
                post_len = CW'(10);
            end else begin
                arm = 1'b0;
            end
            exp_q.push_back(din);
            tick();
            check("rd_valid_timing", {31'b0, rd_valid}, {31'b0, (i == eff - 1)});
        end
        trig = 1'b0;
        arm  = 1'b0;
        din  = 8'hEE;
    endtask

    task automatic drain(input int eff, input bit bp);
        int sent = 0;
        int cyc  = 0;
        while (sent < eff && cyc < 200) begin
            rd_ready = bp ? bp_pat[cyc % 4] : 1'b1;
            if (rd_ready && rd_valid) sent++;
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        check("drain_count", sent, eff);
    endtask

    task automatic check_done();
        check("done_pulse", {31'b0, done}, 1);
        check("busy_at_done", {31'b0, busy}, 0);
        check("valid_at_done", {31'b0, rd_valid}, 0);
        check("queue_empty", exp_q.size(), 0);
        exp_done++;
    endtask

`ifdef CAPTURE_TS_EN
    task automatic wait_ts(input logic [15:0] tgt);
        int n = 0;
        while (tb_ts != tgt && n < 70000) begin
            tick();
            n++;
        end
        check("ts_wait", {16'b0, tb_ts}, {16'b0, tgt});
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        #13;
        rst_n = 1'b1;
        tick();
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_armed", {31'b0, armed}, 0);
        check("rst_valid", {31'b0, rd_valid}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_data", {24'b0, rd_data}, 0);
        check("rst_len", {27'b0, dut.r_len}, 1);
        check("rst_wr_cnt", {27'b0, dut.r_wr_cnt}, 0);
        check("rst_rd_cnt", {27'b0, dut.r_rd_cnt}, 0);

        // basic burst of four
        do_arm(4);
        repeat (3) tick();
        do_capture(4, 8'h10, 1'b0);
        drain(4, 1'b0);
        check_done();
        tick();
        check("done_one_cycle", {31'b0, done}, 0);

        // length clamping
        do_arm(0);
        do_capture(1, 8'h40, 1'b0);
        drain(1, 1'b0);
        check_done();
        tick();
        do_arm(31);
        do_capture(16, 8'h80, 1'b0);
        drain(16, 1'b0);
        check_done();
        tick();

        // backpressure
        do_arm(5);
        tick();
        do_capture(5, 8'h20, 1'b0);
        drain(5, 1'b1);
        check_done();
        tick();

        // trigger in IDLE
        trig = 1'b1;
        repeat (3) tick();
        trig = 1'b0;
        check("idle_trig_busy", {31'b0, busy}, 0);
        check("idle_trig_valid", {31'b0, rd_valid}, 0);

        // arm during capture is ignored, then back-to-back re-arm in the done cycle
        do_arm(3);
        do_capture(3, 8'h30, 1'b1);
        check("len_kept", {27'b0, dut.r_len}, 3);
        drain(3, 1'b0);
        check_done();
        do_arm(2);
        do_capture(2, 8'h50, 1'b0);
        drain(2, 1'b0);
        check_done();
        tick();

        // aborts
        d0 = done_cnt;
        do_arm(4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_armed_busy", {31'b0, busy}, 0);
        check("abort_armed_armed", {31'b0, armed}, 0);

        do_arm(8);
        din  = 8'h60;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_cap_busy", {31'b0, busy}, 0);
        repeat (10) tick();
        check("abort_cap_stays_idle", {31'b0, busy}, 0);
        check("abort_cap_wr_cnt", {27'b0, dut.r_wr_cnt}, 0);

        do_arm(4);
        do_capture(4, 8'h70, 1'b0);
        rd_ready = 1'b1;
        repeat (2) tick();
        rd_ready = 1'b0;
        abort    = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_drain_valid", {31'b0, rd_valid}, 0);
        check("abort_drain_busy", {31'b0, busy}, 0);
        check("abort_drain_done", {31'b0, done}, 0);
        exp_q.delete();

        do_arm(2);
        do_capture(2, 8'h90, 1'b0);
        rd_ready = 1'b1;
        tick();
        abort = 1'b1;
        tick();
        abort    = 1'b0;
        rd_ready = 1'b0;
        check("abort_last_done", {31'b0, done}, 0);
        check("abort_last_busy", {31'b0, busy}, 0);
        exp_q.delete();

        arm      = 1'b1;
        abort    = 1'b1;
        post_len = CW'(4);
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        check("arm_abort_busy", {31'b0, busy}, 0);
        check("arm_abort_armed", {31'b0, armed}, 0);
        tick();
        check("no_done_after_aborts", done_cnt, d0);

        // asynchronous reset mid-drain
        do_arm(4);
        do_capture(4, 8'hA0, 1'b0);
        rd_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, rd_valid}, 0);
        check("async_rst_busy", {31'b0, busy}, 0);
        #3;
        rst_n = 1'b1;
        exp_q.delete();
        tick();
        check("async_rst_len", {27'b0, dut.r_len}, 1);

        // recovery after reset
        do_arm(3);
        do_capture(3, 8'hC0, 1'b0);
        drain(3, 1'b0);
        check_done();
        tick();

`ifdef CAPTURE_TS_EN
        do_arm(1);
        wait_ts(16'h0123);
        do_capture(1, 8'h55, 1'b0);
        check("trig_ts_0123", {16'b0, trig_ts}, 32'h0123);
        drain(1, 1'b0);
        check_done();
        repeat (5) tick();
        check("trig_ts_held", {16'b0, trig_ts}, 32'h0123);
        do_arm(1);
        wait_ts(16'hFFFF);
        do_capture(1, 8'h56, 1'b0);
        check("trig_ts_ffff", {16'b0, trig_ts}, 32'hFFFF);
        drain(1, 1'b0);
        check_done();
        do_arm(1);
        wait_ts(16'h0004);
        do_capture(1, 8'h57, 1'b0);
        check("trig_ts_wrapped", {16'b0, trig_ts}, 32'h0004);
        drain(1, 1'b0);
        check_done();
        tick();
`endif

        repeat (2) tick();
        check("done_total", done_cnt, exp_done);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
